// File: rtl/u2_pkg.sv
// Shared types and helpers for the U2 accumulator family.
// Holds the FSM state type, the default sizes and the saturating clamp.
package u2_pkg;

    localparam int NUM_DEF = 4;
    localparam int CNT_DEF = 4;

    typedef enum logic {ST_ACC, ST_OUT} acc_state_t;

    // Clamps a sign-extended value into the signed range of a 'width'-bit word.
    function automatic logic signed [31:0] sat_u2(input logic signed [31:0] value,
                                                  input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/u2_sext_neg.sv
// Sign-extends a NUM-bit U2 operand to ACC_W bits and optionally negates it.
// Negation happens after the extension, so the most-negative input maps to an exact positive value.
module u2_sext_neg
    import u2_pkg::*;
#(
    parameter int NUM   = NUM_DEF,
    parameter int ACC_W = NUM + 3
) (
    input  logic [NUM-1:0]   i_arg,
    input  logic             i_sub,
    output logic [ACC_W-1:0] o_term
);

    logic [ACC_W-1:0] w_ext;

    assign w_ext  = {{(ACC_W - NUM){i_arg[NUM-1]}}, i_arg};
    assign o_term = i_sub ? -w_ext : w_ext;

endmodule

// File: rtl/u2_accumulator.sv
// Frame accumulator for U2 samples: sums CNT accepted samples and presents the total on a valid/ready port.
// Optional clamp of the frame sum to the NUM-bit signed range is enabled by defining U2_ACC_SAT_EN.
module u2_accumulator
    import u2_pkg::*;
#(
    parameter int NUM   = NUM_DEF,
    parameter int CNT   = CNT_DEF,
    parameter int ACC_W = NUM + 1 + $clog2(CNT)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [NUM-1:0]   i_arg,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_sat
);

    localparam int               CNT_W = $clog2(CNT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CNT - 1);

    acc_state_t              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sat;

    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_next;
    logic signed [ACC_W-1:0] w_sum_out;
    logic                    w_sat_out;
    logic                    w_accept;

    u2_sext_neg #(
        .NUM   (NUM),
        .ACC_W (ACC_W)
    ) u_sext_neg (
        .i_arg  (i_arg),
        .i_sub  (i_sub),
        .o_term (w_term)
    );

    assign w_accept = i_valid && (r_state == ST_ACC);
    assign w_next   = r_acc + w_term;

`ifdef U2_ACC_SAT_EN
    logic signed [31:0] w_next_ext;
    logic signed [31:0] w_clamped;

    assign w_next_ext = 32'(w_next);
    assign w_clamped  = sat_u2(w_next_ext, NUM);
    assign w_sum_out  = w_clamped[ACC_W-1:0];
    assign w_sat_out  = (w_clamped != w_next_ext);
`else
    assign w_sum_out  = w_next;
    assign w_sat_out  = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        if (r_cnt == LAST) begin
                            r_sum   <= w_sum_out;
                            r_sat   <= w_sat_out;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_OUT;
                        end else begin
                            r_acc <= w_next;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (i_ready)
                        r_state <= ST_ACC;
                end
            endcase
        end
    end

    // Handshake flags decode straight from the state register, so reset clears o_valid at once.
    assign o_ready = (r_state == ST_ACC);
    assign o_valid = (r_state == ST_OUT);
    assign o_sum   = r_sum;
    assign o_sat   = r_sat;

endmodule

// File: doc/u2_accumulator.md
Name: u2_accumulator

Overview:
Frame accumulator for two's-complement (U2) operands, placed directly downstream of the sign-change stage. Each accepted sample is NUM-bit signed, sign-extended to ACC_W bits, then added or subtracted per i_sub. After CNT accepted samples, the frame sum is presented on a valid/ready output and the accumulator restarts.

Parameters:
NUM, 4, operand width in bits (U2, signed)
CNT, 4, samples per frame; must be >= 2
ACC_W, NUM+1+$clog2(CNT), accumulator/result width; derived, not overridden

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_valid  input  1  input sample valid
o_ready  output  1  block can accept a sample
i_arg  input  NUM  signed operand (U2)
i_sub  input  1  1: subtract i_arg, 0: add i_arg; sampled with i_arg
o_valid  output  1  o_sum holds a completed frame sum
i_ready  input  1  downstream accepts o_sum
o_sum  output  ACC_W  signed frame sum
o_sat  output  1  saturation flag (see Optional Feature)

Behaviour:
- One clock (i_clk); reset asynchronous, active-low (i_rstn). Reset values: acc=0, cnt=0, state=ST_ACC, o_valid=0, o_sum=0, o_sat=0. o_ready=1 in the first cycle after reset deasserts.
- FSM states:
  - ST_ACC: o_ready=1, o_valid=0.
  - ST_OUT: o_ready=0, o_valid=1.
- In ST_ACC, a sample is accepted when i_valid && o_ready:
  - term = sext(i_arg) when i_sub=0, else -sext(i_arg), computed at ACC_W bits.
  - acc <= acc + term; cnt <= cnt + 1.
- On accepting sample number CNT (cnt==CNT-1):
  - o_sum <= acc + term; state <= ST_OUT; o_valid rises on the next cycle (1-cycle latency).
  - acc <= 0; cnt <= 0.
- In ST_OUT:
  - o_sum and o_sat are held stable while i_ready=0.
  - On i_ready, state <= ST_ACC the next cycle, which reopens o_ready.
  - There is no same-cycle passthrough, so one bubble cycle occurs per frame.
- Inputs while o_ready=0 are ignored. i_arg and i_sub are don't-care when i_valid=0.
- Arithmetic:
  - Negating the most-negative value, e.g. 4'b1000 -> +8, is exact because negation happens after sign-extension to ACC_W.
  - ACC_W guarantees no wrap: |sum| <= CNT*2^(NUM-1).
- Reset mid-frame discards the partial sum and any pending output. o_valid drops immediately (asynchronously).
- i_valid held high continuously gives one sample per cycle in ST_ACC.

Optional Feature:
Macro U2_ACC_SAT_EN.
- Defined: when the frame sum leaves the NUM-bit signed range [-2^(NUM-1), 2^(NUM-1)-1]:
  - o_sum is clamped to the nearest bound, sign-extended to ACC_W.
  - o_sat=1 for that frame, registered together with o_sum.
- Undefined: o_sum is the full ACC_W sum and o_sat is tied to 0.

Decomposition:
- Package u2_pkg holds:
  - typedef enum logic {ST_ACC, ST_OUT} acc_state_t
  - function sat_u2(value, width) for clamping
  - localparam defaults NUM_DEF=4, CNT_DEF=4
- One sub-module, u2_sext_neg:
  - Parameters NUM and ACC_W; combinational sign-extend plus conditional negate.
  - Inputs i_arg and i_sub; output o_term.
  - Shared with the sign-change stage family.

Test Plan:
1. Reset: assert i_rstn=0 mid-frame, after 2 of 4 samples -> o_valid=0, o_sum=0, o_ready=1 after release; next frame sums from 0.
2. Add frame, NUM=4, CNT=4, i_sub=0: i_arg = 0011, 1110, 0111, 1000 (3, -2, 7, -8) -> o_sum=0, o_valid high 1 cycle after the 4th accept, o_sat=0.
3. Subtract with most-negative: i_sub=1, i_arg=1000 four times -> o_sum=+32 (7'b0100000). With U2_ACC_SAT_EN: o_sum=+7, o_sat=1.
4. Negative saturation: i_sub=0, i_arg=1000 four times -> o_sum=-32. With U2_ACC_SAT_EN: o_sum=-8, o_sat=1.
5. Backpressure: hold i_ready=0 for 5 cycles after o_valid while toggling i_valid/i_arg -> o_sum stable, o_ready=0, no samples absorbed. Raise i_ready -> o_ready=1 the next cycle.
6. Gapped input: i_valid pattern 1,0,1,0,0,1,1 with i_arg=0001, i_sub=0 -> exactly 4 accepts, o_sum=4.
